// File: rtl/result_log.sv
// result_log: circular log of the last DEPTH ALU results with flags, with a
// LIVE/BROWSE viewer that can step back through older entries and
// auto-returns to LIVE after TIMEOUT idle cycles in BROWSE.
// Optional feature: define RESULT_LOG_VCOUNT_EN to add the VCNT overflow counter.
module result_log #(
  parameter int N       = 8,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 250_000_000
) (
  input  logic                     CLK50M,
  input  logic                     RSTb,
  input  logic                     commit,
  input  logic [N-1:0]             RESULT,
  input  logic [3:0]               FLAGS,
  input  logic                     browse,
  input  logic                     live,
  output logic [N-1:0]             VIEW,
  output logic [3:0]               VIEW_FLAGS,
  output logic [$clog2(DEPTH)-1:0] AGE,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     BROWSING,
  output logic                     OVW
`ifdef RESULT_LOG_VCOUNT_EN
  ,
  output logic [7:0]               VCNT
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] TLAST     = TW'(TIMEOUT - 1);

  typedef enum logic {LIVE, BROWSE} state_t;

  logic [N+3:0]  mem [DEPTH];
  state_t        state_reg, state_next;
  logic [AW-1:0] wptr_reg, wptr_next;
  logic [AW:0]   count_reg, count_next;
  logic [AW-1:0] age_reg, age_next;
  logic [AW:0]   age_calc;
  logic [TW-1:0] tcnt_reg, tcnt_next;
  logic          ovw_reg;
  logic [N+3:0]  view_reg;
  logic [AW-1:0] rd_addr;

  // Next-state: pointer/count update, viewer state, age tracking and timeout.
  always_comb begin
    wptr_next  = wptr_reg;
    count_next = count_reg;
    state_next = state_reg;
    age_calc   = {1'b0, age_reg};
    tcnt_next  = '0;

    if (commit) begin
      wptr_next = wptr_reg + 1'b1;
      if (count_reg != DEPTH_C) count_next = count_reg + 1'b1;
    end

    if (live) begin
      state_next = LIVE;
      age_calc   = '0;
    end else if (state_reg == LIVE) begin
      age_calc = '0;
      // count_reg is nonzero here, so count_next >= 1.
      if (browse && (count_reg != '0)) begin
        state_next = BROWSE;
        age_calc   = (count_next > (AW + 1)'(1)) ? (AW + 1)'(1) : '0;
      end
    end else begin
      // Keep the same entry in view as newer ones arrive; if it was
      // overwritten, settle on the oldest surviving entry.
      if (commit) begin
        age_calc = age_calc + 1'b1;
        if (age_calc > count_next - 1'b1) age_calc = count_next - 1'b1;
      end
      if (browse) begin
        age_calc = age_calc + 1'b1;
        if (age_calc > count_next - 1'b1) age_calc = '0;
      end else if (tcnt_reg == TLAST) begin
        state_next = LIVE;
        age_calc   = '0;
      end
      if (state_next == BROWSE && !browse) tcnt_next = tcnt_reg + 1'b1;
    end
  end

  assign age_next = age_calc[AW-1:0];
  // Entry at age a lives a+1 slots behind the write pointer after this cycle.
  assign rd_addr  = wptr_next - 1'b1 - age_next;

  // Log storage write; reset suppresses a same-cycle commit.
  always_ff @(posedge CLK50M) begin
    if (RSTb && commit) mem[wptr_reg] <= {FLAGS, RESULT};
  end

  // Registered view: bypass the entry being written when it is the one viewed.
  always_ff @(posedge CLK50M) begin
    if (!RSTb)                     view_reg <= '0;
    else if (count_next == '0)     view_reg <= '0;
    else if (commit && age_next == '0) view_reg <= {FLAGS, RESULT};
    else                           view_reg <= mem[rd_addr];
  end

  // Control state registers.
  always_ff @(posedge CLK50M) begin
    if (!RSTb) begin
      state_reg <= LIVE;
      wptr_reg  <= '0;
      count_reg <= '0;
      age_reg   <= '0;
      tcnt_reg  <= '0;
      ovw_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      wptr_reg  <= wptr_next;
      count_reg <= count_next;
      age_reg   <= age_next;
      tcnt_reg  <= tcnt_next;
      if (commit && count_reg == DEPTH_C) ovw_reg <= 1'b1;
    end
  end

  assign VIEW       = view_reg[N-1:0];
  assign VIEW_FLAGS = view_reg[N+3:N];
  assign AGE        = age_reg;
  assign COUNT      = count_reg;
  assign EMPTY      = (count_reg == '0);
  assign FULL       = (count_reg == DEPTH_C);
  assign BROWSING   = (state_reg == BROWSE);
  assign OVW        = ovw_reg;

`ifdef RESULT_LOG_VCOUNT_EN
  logic [7:0] vcnt_reg;

  // Saturating count of committed results with the overflow flag set.
  always_ff @(posedge CLK50M) begin
    if (!RSTb)                                        vcnt_reg <= '0;
    else if (commit && FLAGS[3] && vcnt_reg != 8'hFF) vcnt_reg <= vcnt_reg + 1'b1;
  end

  assign VCNT = vcnt_reg;
`endif

endmodule

// File: tb/tb_result_log.sv
// tb_result_log: directed vector table plus hand-written sequences for
// wrap, overwrite clamp, timeout and reset corner cases.
module tb_result_log;

  logic       clk = 1'b0;
  logic       rst_b, commit, browse, live;
  logic [7:0] result;
  logic [3:0] flags;
  logic [7:0] view;
  logic [3:0] view_flags;
  logic [2:0] age;
  logic [3:0] count;
  logic       empty, full, browsing, ovw;
`ifdef RESULT_LOG_VCOUNT_EN
  logic [7:0] vcnt;
`endif

  int errors = 0;
  int checks = 0;

  always #10 clk = ~clk;

  result_log #(.N(8), .DEPTH(8), .TIMEOUT(10)) dut (
    .CLK50M(clk), .RSTb(rst_b), .commit(commit), .RESULT(result), .FLAGS(flags),
    .browse(browse), .live(live), .VIEW(view), .VIEW_FLAGS(view_flags),
    .AGE(age), .COUNT(count), .EMPTY(empty), .FULL(full),
    .BROWSING(browsing), .OVW(ovw)
`ifdef RESULT_LOG_VCOUNT_EN
    , .VCNT(vcnt)
`endif
  );

  typedef struct {
    logic       c;
    logic [7:0] r;
    logic [3:0] f;
    logic       b;
    logic       l;
    logic [7:0] ev;
    logic [3:0] ef;
    logic [2:0] ea;
    logic [3:0] ec;
    logic       eb;
    logic       eo;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic c, input logic [7:0] r, input logic [3:0] f,
                      input logic b, input logic l, input logic rn);
    commit = c; result = r; flags = f; browse = b; live = l; rst_b = rn;
    @(posedge clk);
    #1;
    commit = 1'b0; browse = 1'b0; live = 1'b0; rst_b = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    commit = 0; browse = 0; live = 0; result = 0; flags = 0; rst_b = 0;

    //            c  r      f        b  l  view   vf     age   cnt  br  ovw
    tbl[0]  = '{1, 8'h3C, 4'b0000, 0, 0, 8'h3C, 4'h0, 3'd0, 4'd1, 0, 0};
    tbl[1]  = '{0, 8'h00, 4'b0000, 1, 0, 8'h3C, 4'h0, 3'd0, 4'd1, 1, 0};
    tbl[2]  = '{0, 8'h00, 4'b0000, 0, 1, 8'h3C, 4'h0, 3'd0, 4'd1, 0, 0};
    tbl[3]  = '{1, 8'hA0, 4'b0001, 0, 0, 8'hA0, 4'h1, 3'd0, 4'd2, 0, 0};
    tbl[4]  = '{1, 8'hA1, 4'b0010, 0, 0, 8'hA1, 4'h2, 3'd0, 4'd3, 0, 0};
    tbl[5]  = '{0, 8'h00, 4'b0000, 1, 0, 8'hA0, 4'h1, 3'd1, 4'd3, 1, 0};
    tbl[6]  = '{1, 8'hA2, 4'b0100, 0, 0, 8'hA0, 4'h1, 3'd2, 4'd4, 1, 0};
    tbl[7]  = '{1, 8'hA3, 4'b1000, 1, 0, 8'h3C, 4'h0, 3'd4, 4'd5, 1, 0};
    tbl[8]  = '{0, 8'h00, 4'b0000, 1, 0, 8'hA3, 4'h8, 3'd0, 4'd5, 1, 0};
    tbl[9]  = '{0, 8'h00, 4'b0000, 0, 0, 8'hA3, 4'h8, 3'd0, 4'd5, 1, 0};
    tbl[10] = '{1, 8'h55, 4'b0000, 1, 1, 8'h55, 4'h0, 3'd0, 4'd6, 0, 0};

    // Reset state
    step(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst_view", 0, view, 0);
    chk("rst_count", 0, count, 0);
    chk("rst_empty", 0, empty, 1);
    chk("rst_age", 0, age, 0);
    chk("rst_browsing", 0, browsing, 0);
    chk("rst_ovw", 0, ovw, 0);
    $display("reset: view=%0h count=%0d empty=%0b", view, count, empty);

    // Empty browse is ignored
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("empty_browse", 0, browsing, 0);
    $display("browse on empty: browsing=%0b age=%0d", browsing, age);

    // Vector table
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].c, tbl[i].r, tbl[i].f, tbl[i].b, tbl[i].l, 1'b1);
      chk("tbl_view", i, view, tbl[i].ev);
      chk("tbl_vflags", i, view_flags, tbl[i].ef);
      chk("tbl_age", i, age, tbl[i].ea);
      chk("tbl_count", i, count, tbl[i].ec);
      chk("tbl_browsing", i, browsing, tbl[i].eb);
      chk("tbl_ovw", i, ovw, tbl[i].eo);
      $display("vec %0d: c=%0b r=%0h b=%0b l=%0b -> view=%0h age=%0d count=%0d br=%0b",
               i, tbl[i].c, tbl[i].r, tbl[i].b, tbl[i].l, view, age, count, browsing);
    end

    // Fill past DEPTH: overwrite, browse wrap
    step(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) step(1'b1, 8'(i), 4'h0, 1'b0, 1'b0, 1'b1);
    chk("fill_count", 0, count, 8);
    chk("fill_full", 0, full, 1);
    chk("fill_ovw", 0, ovw, 1);
    chk("fill_view", 0, view, 8'h09);
    $display("fill 9: count=%0d full=%0b ovw=%0b view=%0h", count, full, ovw, view);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("browse7_view", 0, view, 8'h02);
    chk("browse7_age", 0, age, 7);
    $display("browse x7: view=%0h age=%0d", view, age);
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("wrap_age", 0, age, 0);
    chk("wrap_view", 0, view, 8'h09);
    chk("wrap_browsing", 0, browsing, 1);
    $display("browse wrap: view=%0h age=%0d", view, age);

    // Overwrite of the viewed oldest entry clamps to the new oldest
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h0A, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("clamp_age", 0, age, 7);
    chk("clamp_view", 0, view, 8'h03);
    $display("commit at oldest: view=%0h age=%0d", view, age);
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("clamp_wrap_view", 0, view, 8'h0A);
    $display("browse: view=%0h age=%0d", view, age);

    // Timeout after 10 idle cycles in BROWSE
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
    idle(9);
    chk("tmo_still_browsing", 0, browsing, 1);
    chk("tmo_age_before", 0, age, 1);
    idle(1);
    chk("tmo_browsing", 0, browsing, 0);
    chk("tmo_age", 0, age, 0);
    chk("tmo_view", 0, view, 8'h0A);
    $display("timeout: browsing=%0b age=%0d view=%0h", browsing, age, view);

    // Reset mid-BROWSE overrides a same-cycle commit
    step(1'b0, 8'h00, 4'h0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h77, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("midrst_count", 0, count, 0);
    chk("midrst_view", 0, view, 0);
    chk("midrst_ovw", 0, ovw, 0);
    chk("midrst_browsing", 0, browsing, 0);
    chk("midrst_empty", 0, empty, 1);
    $display("reset in browse: count=%0d view=%0h ovw=%0b", count, view, ovw);

`ifdef RESULT_LOG_VCOUNT_EN
    for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 4'b0100, 1'b0, 1'b0, 1'b1);
    chk("vcnt_carry_only", 0, vcnt, 0);
    for (int i = 0; i < 300; i++) step(1'b1, 8'h22, 4'b1000, 1'b0, 1'b0, 1'b1);
    chk("vcnt_sat", 0, vcnt, 255);
    step(1'b1, 8'h33, 4'b0100, 1'b0, 1'b0, 1'b1);
    chk("vcnt_hold", 0, vcnt, 255);
    $display("vcnt: %0d", vcnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
